gpioemu_mulpop: RTL and testbench
=================================

Name: gpioemu_mulpop

Overview:
Parametrised next generation of the bus-mapped GPIO emulator arithmetic block. It runs a sequential shift-add multiply of two AW-bit operands, then a popcount of the WW-bit result. Results, status and an operation counter are exposed through the same saddress/srd/swr register bus and gpio_out. All logic sits in one clock domain; bus strobes are sampled synchronously rather than used as clocks.

Parameters:
AW, 24, operand width (A1, A2)
WW, 32, result window width (W); must satisfy WW <= 2*AW and WW <= 32
CW, 16, operation counter width, with CW <= 32
ADDR_A1, 16'h0380, operand A1 register
ADDR_A2, 16'h0388, operand A2 register
ADDR_W, 16'h0390, result W (read-only)
ADDR_L, 16'h0398, popcount L (read-only)
ADDR_CTRL, 16'h03A0, write = start, read = status

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
saddress  in  16  register address
srd  in  1  read strobe, one cycle, sampled on clk
swr  in  1  write strobe, one cycle, sampled on clk
sdata_in  in  32  write data
sdata_out  out  32  registered read data
gpio_in  in  32  raw GPIO input
gpio_latch  in  1  capture enable for gpio_in
gpio_in_s_insp  out  32  latched gpio_in
gpio_out  out  32  {zero-extend, op_count[CW-1:0]}
done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (at a clk edge with reset=1):
  - sdata_out, gpio_in_s, A1, A2, W, L, op_count and done are all 0.
  - state = IDLE; status {ready,valid} = 2'b11.
  - Reset mid-operation aborts the operation and discards partial results.
- gpio_latch=1 at an edge: gpio_in_s <= gpio_in.
- Writes (swr=1):
  - ADDR_A1/ADDR_A2 take sdata_in[AW-1:0] in any state.
  - ADDR_CTRL in IDLE starts an operation; in any other state it is ignored (no restart, no count).
  - Other addresses are ignored.
- Reads (srd=1): sdata_out <= the selected register at that edge, and holds until the next srd.
  - ADDR_W returns W zero-extended.
  - ADDR_L returns L zero-extended.
  - ADDR_CTRL returns {30'b0, ready, valid}.
  - Any other address returns 0.
  - srd and swr in the same cycle: the read returns the pre-write value.
- FSM: IDLE -> MULT -> COUNT -> DONE -> IDLE.
  - IDLE, start at edge k: snapshot A1/A2 into working regs; clear the 2*AW accumulator and bit index; ready=0; go to MULT.
  - MULT: one multiplier bit per edge (k+1..k+AW); add the shifted multiplicand when the bit is 1; after bit AW-1 go to COUNT.
  - COUNT (edge k+AW+1):
    - W = product[WW-1:0].
    - valid = (product[2AW-1:WW] == 0); valid is 1 when 2AW == WW.
    - L = popcount(W), width $clog2(WW+1).
    - Go to DONE.
  - DONE (edge k+AW+2): ready=1; op_count++ (wraps at 2^CW); done=1 for exactly this cycle; go to IDLE.
- Total latency from the start edge to ready=1 is AW+2 edges (26 at defaults).
- Operand writes during busy update A1/A2 but do not affect the running snapshot.
- W, L and valid hold their previous values until COUNT of the next operation.

Optional Feature:
GPIOEMU_MULPOP_ACC_EN:
- With the macro: sdata_in[0] on an ADDR_CTRL start write selects accumulate mode. The product is added to {upper, W} from the previous operation before the window and popcount are taken. valid also clears on carry-out beyond 2*AW.
- Without the macro: bit 0 is ignored and every operation is a plain multiply.

Decomposition:
- Package gpioemu_pkg holds:
  - state enum (IDLE, MULT, COUNT, DONE)
  - status bit positions
  - default address constants
  - popcount function
- One sub-module, gpioemu_shift_mul: AW-parameterised serial shift-add multiplier with start/busy/done handshake. The top level keeps the bus decode, FSM and counters.

Test Plan:
- Reset, then read ADDR_CTRL -> 0x3; read ADDR_W -> 0; gpio_out -> 0.
- A1=3, A2=5, start -> ready after exactly 26 edges; done pulses once. Then:
  - W=0x0000000F
  - L=4
  - status=0x3
  - gpio_out=1
- A1=A2=0xFFFFFF, start -> product 0xFFFFFE000001. Then:
  - W=0xFE000001
  - L=8
  - status=0x2 (valid=0)
- Start, then a second start write and an A1 change at cycle 5 -> result still uses the old A1; gpio_out increments by 1 only.
- Start, assert reset at cycle 10 -> status 0x3; W=0; no done pulse; gpio_out=0.
- Read 0x0000 -> 0. Pulse gpio_latch with gpio_in=0xA5A5A5A5 -> gpio_in_s_insp=0xA5A5A5A5. With ACC_EN:
  - 2*3, then acc 2*3 -> W=12
  - L=2

Source files
------------

// File: rtl/gpioemu_pkg.sv
// Shared types, status bit positions, default register map and popcount helper
// for the gpioemu multiply/popcount block.
package gpioemu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned STAT_VALID = 0;
    localparam int unsigned STAT_READY = 1;

    localparam logic [15:0] ADDR_A1_DEF   = 16'h0380;
    localparam logic [15:0] ADDR_A2_DEF   = 16'h0388;
    localparam logic [15:0] ADDR_W_DEF    = 16'h0390;
    localparam logic [15:0] ADDR_L_DEF    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL_DEF = 16'h03A0;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gpioemu_shift_mul.sv
// Serial shift-add multiplier: one multiplier bit per clock, AW clocks per product.
// last_c flags the clock in which the final bit is consumed.
module gpioemu_shift_mul
    import gpioemu_pkg::*;
#(
    parameter int unsigned AW = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW-1:0]   a,
    input  logic [AW-1:0]   b,
    output logic            busy,
    output logic            last_c,
    output logic [2*AW-1:0] product
);

    localparam int unsigned PW = 2 * AW;
    localparam int unsigned IW = (AW > 1) ? $clog2(AW) : 1;

    logic [PW-1:0] mcand;
    logic [AW-1:0] mplier;
    logic [IW-1:0] idx;

    assign last_c = busy && (idx == IW'(AW - 1));

    // Operands are snapshotted on start so later operand writes cannot disturb the run
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            product <= '0;
        end else if (start && !busy) begin
            mcand   <= PW'(a);
            mplier  <= b;
            idx     <= '0;
            busy    <= 1'b1;
            product <= '0;
        end else if (busy) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            idx    <= idx + IW'(1);
            if (last_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpioemu_mulpop.sv
// Bus-mapped multiply-then-popcount block with status, op counter and GPIO latch.
// Optional accumulate mode is enabled by defining GPIOEMU_MULPOP_ACC_EN.
module gpioemu_mulpop
    import gpioemu_pkg::*;
#(
    parameter int unsigned AW        = 24,
    parameter int unsigned WW        = 32,
    parameter int unsigned CW        = 16,
    parameter logic [15:0] ADDR_A1   = ADDR_A1_DEF,
    parameter logic [15:0] ADDR_A2   = ADDR_A2_DEF,
    parameter logic [15:0] ADDR_W    = ADDR_W_DEF,
    parameter logic [15:0] ADDR_L    = ADDR_L_DEF,
    parameter logic [15:0] ADDR_CTRL = ADDR_CTRL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_in_s_insp,
    output logic [31:0] gpio_out,
    output logic        done
);

    localparam int unsigned PW = 2 * AW;
    localparam int unsigned LW = $clog2(WW + 1);

    state_t         state;
    state_t         state_d;
    logic [AW-1:0]  a1;
    logic [AW-1:0]  a2;
    logic [WW-1:0]  w;
    logic [LW-1:0]  l;
    logic           valid;
    logic [CW-1:0]  op_count;
    logic [31:0]    gpio_in_s;

    logic           start_c;
    logic           mul_busy;
    logic           mul_last_c;
    logic [PW-1:0]  product;
    logic [PW:0]    sum_c;
    logic [1:0]     status_c;
    logic [31:0]    rd_data_c;
    logic           unused_c;

    assign start_c = swr && (saddress == ADDR_CTRL) && (state == IDLE) && !mul_busy;

    gpioemu_shift_mul #(.AW(AW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start_c),
        .a       (a1),
        .b       (a2),
        .busy    (mul_busy),
        .last_c  (mul_last_c),
        .product (product)
    );

`ifdef GPIOEMU_MULPOP_ACC_EN
    logic          acc_mode;
    logic [PW-1:0] acc_full;

    // Extra top bit of the sum catches carry-out so it also clears valid
    assign sum_c = {1'b0, product} + (acc_mode ? {1'b0, acc_full} : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_mode <= 1'b0;
            acc_full <= '0;
        end else begin
            if (start_c) begin
                acc_mode <= sdata_in[0];
            end
            if (state == COUNT) begin
                acc_full <= sum_c[PW-1:0];
            end
        end
    end
`else
    assign sum_c = {1'b0, product};
`endif

    assign unused_c = ^{sdata_in, sum_c};

    always_comb begin
        status_c             = '0;
        status_c[STAT_READY] = (state == IDLE);
        status_c[STAT_VALID] = valid;
    end

    always_comb begin
        rd_data_c = '0;
        case (saddress)
            ADDR_W:    rd_data_c = 32'(w);
            ADDR_L:    rd_data_c = 32'(l);
            ADDR_CTRL: rd_data_c = 32'(status_c);
            default:   rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start_c)    state_d = MULT;
            MULT:    if (mul_last_c) state_d = COUNT;
            COUNT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus registers, result capture and completion bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            sdata_out <= '0;
            gpio_in_s <= '0;
            a1        <= '0;
            a2        <= '0;
            w         <= '0;
            l         <= '0;
            valid     <= 1'b1;
            op_count  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (gpio_latch) begin
                gpio_in_s <= gpio_in;
            end
            if (swr && (saddress == ADDR_A1)) begin
                a1 <= sdata_in[AW-1:0];
            end
            if (swr && (saddress == ADDR_A2)) begin
                a2 <= sdata_in[AW-1:0];
            end
            if (srd) begin
                sdata_out <= rd_data_c;
            end
            if (state == COUNT) begin
                w     <= sum_c[WW-1:0];
                l     <= LW'(popcount32(32'(sum_c[WW-1:0])));
                valid <= ((sum_c >> WW) == '0);
            end
            if (state == DONE) begin
                op_count <= op_count + CW'(1);
            end
        end
    end

    assign gpio_in_s_insp = gpio_in_s;
    assign gpio_out       = 32'(op_count);

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Scoreboard bench for gpioemu_mulpop: stimulus pushes expected reads and completions,
// a negedge monitor pops and compares them against an arithmetic reference model.
module tb_gpioemu_mulpop;

    localparam int unsigned AW     = 24;
    localparam logic [15:0] A_A1   = 16'h0380;
    localparam logic [15:0] A_A2   = 16'h0388;
    localparam logic [15:0] A_W    = 16'h0390;
    localparam logic [15:0] A_L    = 16'h0398;
    localparam logic [15:0] A_CTRL = 16'h03A0;
`ifdef GPIOEMU_MULPOP_ACC_EN
    localparam bit ACC_BUILD = 1'b1;
`else
    localparam bit ACC_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic [31:0] gpio_in;
    logic        gpio_latch;
    logic [31:0] gpio_in_s_insp;
    logic [31:0] gpio_out;
    logic        done;

    always #5 clk = ~clk;

    gpioemu_mulpop dut (
        .clk            (clk),
        .reset          (reset),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_in       (sdata_in),
        .sdata_out      (sdata_out),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_in_s_insp (gpio_in_s_insp),
        .gpio_out       (gpio_out),
        .done           (done)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        logic [31:0] gpio;
        int          at;
    } done_exp_t;

    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];
    int        total = 0;
    int        bad   = 0;
    int        cyc   = 0;
    logic      rd_seen = 1'b0;

    // Reference model state
    logic [31:0]     m_a1, m_a2, m_w;
    int              m_l, m_ops;
    bit              m_valid, m_ready;
    longint unsigned m_acc;
    logic [31:0]     p_w;
    int              p_l;
    bit              p_valid;
    longint unsigned p_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= srd && !reset;
    end

    always @(negedge clk) begin : monitor
        rd_exp_t   e;
        done_exp_t d;
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'(rd_q.size()), 32'd1);
            end else begin
                e = rd_q.pop_front();
                check(e.name, sdata_out, e.val);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", {31'b0, done}, 32'd0);
            end else begin
                d = done_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(d.at));
                check("done_gpio_out", gpio_out, d.gpio);
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [15:0] a);
        case (a)
            A_W:     return m_w;
            A_L:     return 32'(m_l);
            A_CTRL:  return {30'b0, m_ready, m_valid};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_a1 = 0; m_a2 = 0; m_w = 0; m_l = 0; m_ops = 0;
        m_valid = 1'b1; m_ready = 1'b1; m_acc = 0;
    endtask

    // Plain product, optionally plus the previous full-width result
    task automatic model_compute(input bit acc_sel);
        longint unsigned s;
        s = 64'(m_a1) * 64'(m_a2);
        if (ACC_BUILD && acc_sel) s = s + m_acc;
        p_valid = ((s >> 32) == 0);
        p_acc   = s & ((64'd1 << 48) - 64'd1);
        p_w     = s[31:0];
        p_l     = $countones(p_w);
    endtask

    task automatic model_commit();
        m_w = p_w; m_l = p_l; m_valid = p_valid; m_acc = p_acc;
        m_ready = 1'b1;
        m_ops = (m_ops + 1) % 65536;
    endtask

    task automatic bus(input bit r, input bit wv, input logic [15:0] a,
                       input logic [31:0] d, input string name);
        if (r) rd_q.push_back('{name: name, val: model_read(a)});
        @(negedge clk);
        srd = r; swr = wv; saddress = a; sdata_in = d;
        @(negedge clk);
        srd = 1'b0; swr = 1'b0;
        if (wv && a == A_A1) m_a1 = {8'b0, d[23:0]};
        if (wv && a == A_A2) m_a2 = {8'b0, d[23:0]};
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d, "");
    endtask

    task automatic rd(input logic [15:0] a, input string name);
        bus(1'b1, 1'b0, a, 32'd0, name);
    endtask

    task automatic wait_done();
        for (int i = 0; i < AW + 12; i++) begin
            @(negedge clk);
            if (done_q.size() == 0) break;
        end
        if (done_q.size() != 0) begin
            check("done_timeout", 32'(done_q.size()), 32'd0);
            void'(done_q.pop_front());
        end
    endtask

    task automatic push_done();
        done_q.push_back('{gpio: 32'((m_ops + 1) % 65536), at: cyc + AW + 2});
    endtask

    task automatic run_op(input logic [31:0] a1v, input logic [31:0] a2v, input bit acc_sel);
        wr(A_A1, a1v);
        wr(A_A2, a2v);
        model_compute(acc_sel);
        bus(1'b1, 1'b1, A_CTRL, {$urandom_range(0, 255) << 1, acc_sel}, "ctrl_pre_start");
        m_ready = 1'b0;
        push_done();
        rd(A_W, "w_hold_busy");
        rd(A_CTRL, "ctrl_busy");
        wait_done();
        model_commit();
        rd(A_W, "w");
        rd(A_L, "l");
        rd(A_CTRL, "ctrl_idle");
        @(negedge clk);
        check("gpio_out", gpio_out, 32'(m_ops));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; srd = 1'b0; swr = 1'b0; saddress = '0; sdata_in = '0;
        gpio_in = '0; gpio_latch = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_sdata_out", sdata_out, 32'd0);
        check("rst_gpio_out", gpio_out, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_gpio_in_s", gpio_in_s_insp, 32'd0);
        rd(A_CTRL, "rst_ctrl");
        rd(A_W, "rst_w");
        rd(A_L, "rst_l");

        run_op(32'd3, 32'd5, 1'b0);
        run_op(32'hFFFFFF, 32'hFFFFFF, 1'b0);
        rd(16'h0000, "rd_unmapped");
        rd(A_A1, "rd_a1_unreadable");

        // Restart attempt and operand write while busy
        wr(A_A1, 32'd7);
        wr(A_A2, 32'd9);
        model_compute(1'b0);
        wr(A_CTRL, 32'd0);
        m_ready = 1'b0;
        push_done();
        repeat (3) @(negedge clk);
        wr(A_CTRL, 32'd0);
        wr(A_A1, 32'd100);
        wait_done();
        model_commit();
        rd(A_W, "w_busy_snapshot");
        @(negedge clk);
        check("gpio_out_busy", gpio_out, 32'(m_ops));
        run_op(m_a1, m_a2, 1'b0);

        // Reset mid-operation
        wr(A_A1, 32'd11);
        wr(A_A2, 32'd13);
        wr(A_CTRL, 32'd0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (AW + 6) @(negedge clk);
        rd(A_CTRL, "ctrl_after_abort");
        rd(A_W, "w_after_abort");
        rd(A_L, "l_after_abort");
        @(negedge clk);
        check("gpio_out_after_abort", gpio_out, 32'd0);

        // GPIO capture
        gpio_in = 32'hA5A5A5A5;
        gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0;
        gpio_in = 32'h12345678;
        @(negedge clk);
        check("gpio_latched", gpio_in_s_insp, 32'hA5A5A5A5);

        // Plain then accumulate (accumulates only when the feature is built in)
        run_op(32'd2, 32'd3, 1'b0);
        run_op(32'd2, 32'd3, 1'b1);

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom & 32'h00FFFFFF;
            rb = $urandom & 32'h00FFFFFF;
            if ($urandom_range(0, 2) == 0) ra = $urandom_range(0, 255);
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
